// File: rtl/alu_exec.sv
// alu_exec: 16-bit execute stage with registered result/flags.
// Single-cycle ALU ops plus a 16-step shift-add multiplier with busy stall.
module alu_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_in,
  input  logic [15:0] alu_a,
  input  logic [15:0] alu_b,
  input  logic [3:0]  alu_func,
  output logic [15:0] alu_out,
  output logic        zf,
  output logic        nf,
  output logic        cf,
  output logic        vf,
  output logic        en_out,
  output logic        busy
);

  typedef enum logic [0:0] {
    IDLE,
    MUL
  } state_t;

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_AND = 4'd2;
  localparam logic [3:0] F_OR  = 4'd3;
  localparam logic [3:0] F_XOR = 4'd4;
  localparam logic [3:0] F_NOT = 4'd5;
  localparam logic [3:0] F_SHL = 4'd6;
  localparam logic [3:0] F_SHR = 4'd7;
  localparam logic [3:0] F_SAR = 4'd8;
  localparam logic [3:0] F_MOV = 4'd9;
  localparam logic [3:0] F_CMP = 4'd10;
  localparam logic [3:0] F_MUL = 4'd11;

  state_t      state;
  state_t      state_nx;
  logic [31:0] mcand;
  logic [15:0] mplier;
  logic [31:0] acc;
  logic [4:0]  cnt;

  logic [16:0] sum;
  logic [16:0] diff;
  logic [31:0] shl_t;
  logic [16:0] shr_t;
  logic [16:0] sar_t;
  logic [15:0] r;
  logic        c;
  logic        v;
  logic        wr_out;
  logic        wr_flg;
  logic [31:0] acc_step;
  logic        mul_last;
  logic        accept;
  logic        start_mul;

  assign busy      = (state == MUL);
  assign accept    = en_in && (state == IDLE);
  assign start_mul = accept && (alu_func == F_MUL);
  assign mul_last  = (cnt == 5'd1);
  assign acc_step  = acc + (mplier[0] ? mcand : 32'd0);

  // A zero appended below the LSB catches the last bit shifted out.
  assign sum   = {1'b0, alu_a} + {1'b0, alu_b};
  assign diff  = {1'b0, alu_a} - {1'b0, alu_b};
  assign shl_t = {16'd0, alu_a} << alu_b[3:0];
  assign shr_t = {alu_a, 1'b0} >> alu_b[3:0];
  assign sar_t = $signed({alu_a, 1'b0}) >>> alu_b[3:0];

  always_comb begin
    r      = alu_a;
    c      = 1'b0;
    v      = 1'b0;
    wr_out = 1'b1;
    wr_flg = 1'b1;
    unique case (alu_func)
      F_ADD: begin
        r = sum[15:0];
        c = sum[16];
        v = (alu_a[15] == alu_b[15]) && (r[15] != alu_a[15]);
      end
      F_SUB, F_CMP: begin
        r      = diff[15:0];
        c      = diff[16];
        v      = (alu_a[15] != alu_b[15]) && (r[15] != alu_a[15]);
        wr_out = (alu_func == F_SUB);
      end
      F_AND: r = alu_a & alu_b;
      F_OR:  r = alu_a | alu_b;
      F_XOR: r = alu_a ^ alu_b;
      F_NOT: r = ~alu_a;
      F_SHL: begin
        r = shl_t[15:0];
        c = shl_t[16];
      end
      F_SHR: begin
        r = shr_t[16:1];
        c = shr_t[0];
      end
      F_SAR: begin
        r = sar_t[16:1];
        c = sar_t[0];
      end
      F_MOV: r = alu_b;
      default: wr_flg = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_mul) state_nx = MUL;
      MUL:     if (mul_last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_out <= 16'd0;
      zf      <= 1'b0;
      nf      <= 1'b0;
      cf      <= 1'b0;
      vf      <= 1'b0;
      en_out  <= 1'b0;
      mcand   <= 32'd0;
      mplier  <= 16'd0;
      acc     <= 32'd0;
      cnt     <= 5'd0;
    end else begin
      en_out <= 1'b0;
      if (start_mul) begin
        mcand  <= {16'd0, alu_a};
        mplier <= alu_b;
        acc    <= 32'd0;
        cnt    <= 5'd16;
      end else if (accept) begin
        if (wr_out) alu_out <= r;
        if (wr_flg) begin
          zf <= (r == 16'd0);
          nf <= r[15];
          cf <= c;
          vf <= v;
        end
        en_out <= 1'b1;
      end else if (busy) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 5'd1;
        if (mul_last) begin
          alu_out <= acc_step[15:0];
          zf      <= (acc_step[15:0] == 16'd0);
          nf      <= acc_step[15];
          cf      <= |acc_step[31:16];
          vf      <= 1'b0;
          en_out  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: randomized + directed bench for alu_exec.
// Outputs are compared every cycle against a behavioural model.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_in;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_func;
  logic [15:0] alu_out;
  logic        zf, nf, cf, vf, en_out, busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit checking = 1'b0;

  logic [15:0] m_out;
  bit m_zf, m_nf, m_cf, m_vf, m_en, m_busy;

  alu_exec dut (
    .clk(clk), .rst(rst), .en_in(en_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_out(alu_out), .zf(zf), .nf(nf), .cf(cf), .vf(vf),
    .en_out(en_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", name, got, exp);
  endtask

  function automatic int sx(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  function automatic void ref_op(input int f, input int a, input int b,
                                 output int r, output bit c, output bit v);
    int n, ss;
    n = b % 16;
    c = 0;
    v = 0;
    r = a;
    case (f)
      0: begin
        r = (a + b) % 65536;
        c = (a + b) > 65535;
        ss = sx(a) + sx(b);
        v = (ss > 32767) || (ss < -32768);
      end
      1, 10: begin
        r = (a - b + 65536) % 65536;
        c = a < b;
        ss = sx(a) - sx(b);
        v = (ss > 32767) || (ss < -32768);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 65535 - a;
      6: begin
        r = (a << n) % 65536;
        c = (n != 0) && (((a >> (16 - n)) % 2) == 1);
      end
      7: begin
        r = a >> n;
        c = (n != 0) && (((a >> (n - 1)) % 2) == 1);
      end
      8: begin
        r = (sx(a) >>> n) & 65535;
        c = (n != 0) && (((a >> (n - 1)) % 2) == 1);
      end
      9: r = b;
      default: r = a;
    endcase
  endfunction

  // Model: updated at each rising edge from the inputs the DUT sampled.
  initial begin
    int cyc, done_cyc, r, mul_r;
    bit c, v, mul_c;
    longint p;
    cyc = 0; done_cyc = 0; mul_r = 0; mul_c = 0;
    m_out = 0; m_zf = 0; m_nf = 0; m_cf = 0; m_vf = 0;
    m_en = 0; m_busy = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        m_out = 0; m_zf = 0; m_nf = 0; m_cf = 0; m_vf = 0;
        m_en = 0; m_busy = 0;
      end else if (m_busy) begin
        m_en = 0;
        if (cyc == done_cyc) begin
          m_out = mul_r[15:0];
          m_zf = (mul_r == 0);
          m_nf = mul_r[15];
          m_cf = mul_c;
          m_vf = 0;
          m_en = 1;
          m_busy = 0;
        end
      end else if (en_in) begin
        if (alu_func == 4'd11) begin
          p = longint'(alu_a) * longint'(alu_b);
          mul_r = int'(p % 65536);
          mul_c = (p / 65536) != 0;
          done_cyc = cyc + 16;
          m_busy = 1;
          m_en = 0;
        end else if (alu_func >= 4'd12) begin
          m_out = alu_a;
          m_en = 1;
        end else begin
          ref_op(int'(alu_func), int'(alu_a), int'(alu_b), r, c, v);
          if (alu_func != 4'd10) m_out = r[15:0];
          m_zf = (r == 0);
          m_nf = r[15];
          m_cf = c;
          m_vf = v;
          m_en = 1;
        end
      end else begin
        m_en = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking)
      chk("cycle", int'({alu_out, zf, nf, cf, vf, en_out, busy}),
          int'({m_out, m_zf, m_nf, m_cf, m_vf, m_en, m_busy}));
  end

  task automatic set_in(input bit e, input int f, input int a, input int b);
    en_in = e;
    alu_func = 4'(f);
    alu_a = 16'(a);
    alu_b = 16'(b);
  endtask

  task automatic wait_mul(input bit poke);
    for (int i = 1; i <= 16; i++) begin
      if (poke) set_in(1, $urandom_range(0, 15), $urandom, $urandom);
      else set_in(0, 0, 0, 0);
      @(negedge clk);
      if (i < 16) chk("mul_busy", int'(busy), 1);
    end
    set_in(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    set_in(1, 0, 16'h1234, 16'h1111);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checking = 1'b1;
    chk("rst_out", int'({alu_out, zf, nf, cf, vf, en_out, busy}), 0);
    rst = 1'b1;
    set_in(1, 0, 16'h7FFF, 16'h0001);
    @(negedge clk);
    chk("add_ovf", int'({alu_out, zf, nf, cf, vf, en_out}),
        int'({16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}));
    set_in(0, 0, 0, 0);
    @(negedge clk);
    chk("add_en_drop", int'({en_out, alu_out}), int'({1'b0, 16'h8000}));
    set_in(1, 1, 3, 5);
    @(negedge clk);
    chk("sub", int'({alu_out, cf, nf}), int'({16'hFFFE, 1'b1, 1'b1}));
    set_in(1, 10, 5, 5);
    @(negedge clk);
    chk("cmp", int'({alu_out, zf, cf, en_out}), int'({16'hFFFE, 1'b1, 1'b0, 1'b1}));
    set_in(1, 7, 16'h8001, 1);
    @(negedge clk);
    chk("shr", int'({alu_out, cf}), int'({16'h4000, 1'b1}));
    set_in(1, 8, 16'h8000, 15);
    @(negedge clk);
    chk("sar", int'({alu_out, nf}), int'({16'hFFFF, 1'b1}));
    set_in(1, 6, 16'h1234, 0);
    @(negedge clk);
    chk("shl0", int'({alu_out, cf}), int'({16'h1234, 1'b0}));
    set_in(1, 11, 16'h0100, 16'h0100);
    @(negedge clk);
    chk("mul_start", int'({busy, en_out}), int'({1'b1, 1'b0}));
    wait_mul(1);
    chk("mul_big", int'({alu_out, zf, cf, en_out, busy}),
        int'({16'h0000, 1'b1, 1'b1, 1'b1, 1'b0}));
    set_in(1, 11, 16'h00FF, 16'h0003);
    @(negedge clk);
    wait_mul(0);
    chk("mul_small", int'({alu_out, cf, en_out}), int'({16'h02FD, 1'b0, 1'b1}));
    set_in(1, 11, 16'h00FF, 16'h0003);
    @(negedge clk);
    set_in(0, 0, 0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_mul", int'({alu_out, busy, en_out, cf}), 0);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_late_en", int'(en_out), 0);
    end
    set_in(1, 0, 1, 1);
    @(negedge clk);
    chk("add_after_rst", int'({alu_out, en_out}), int'({16'h0002, 1'b1}));
    for (int i = 0; i < 3000; i++) begin
      int k;
      rst = ($urandom_range(0, 299) != 0);
      k = $urandom_range(0, 5);
      set_in($urandom_range(0, 9) < 7,
             (k == 0) ? 11 : $urandom_range(0, 15),
             (k == 1) ? 16'h7FFF : ((k == 2) ? 16'h8000 : $urandom),
             (k == 3) ? 16'h0001 : $urandom);
      @(negedge clk);
    end
    rst = 1'b1;
    set_in(0, 0, 0, 0);
    repeat (20) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute stage of the 16-bit CPU, directly downstream of the ALU operand mux. Registers a result and status flags for each operand pair presented with `en_in`. Single-cycle ops complete in one clock. MUL runs as a 16-cycle shift-add sequence with a `busy` stall to the upstream stage.

## Interface
- No parameters; data width fixed at 16.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-low.
- `en_in`  in  1  operands valid this cycle.
- `alu_a`  in  16  operand A (from operand mux).
- `alu_b`  in  16  operand B (from operand mux).
- `alu_func`  in  4  operation select, sampled with `en_in`.
- `alu_out`  out  16  registered result.
- `zf`, `nf`, `cf`, `vf`  out  1 each  zero / negative / carry / overflow flags, registered.
- `en_out`  out  1  one-cycle pulse: `alu_out`/flags updated this cycle.
- `busy`  out  1  MUL in progress; `en_in` ignored while high.

## Operation
- Reset (`rst`=0 at a rising edge):
  - `alu_out`, all flags, `en_out` and `busy` go to 0.
  - State goes to IDLE; counter, accumulator and latched operands clear.
- States: IDLE, MUL.
- Accept: `en_in`=1 and `busy`=0 at a rising edge.
- `alu_func` encoding (result R):
  - 0 ADD: R=a+b; cf=bit-16 carry; vf=signed overflow.
  - 1 SUB: R=a-b; cf=1 when a<b unsigned (borrow); vf=signed overflow.
  - 2 AND, 3 OR, 4 XOR, 5 NOT a: cf=0, vf=0.
  - 6 SHL: a << b[3:0], cf=last bit shifted out.
  - 7 SHR: logical right shift, cf=last bit shifted out.
  - 8 SAR: arithmetic right shift, cf=last bit shifted out.
  - Shifts: cf=0 when shift amount is 0; vf=0.
  - 9 MOV: R=b; cf=0, vf=0.
  - 10 CMP: flags exactly as SUB; `alu_out` keeps its previous value.
  - 11 MUL: low 16 bits of unsigned 32-bit product; cf=1 when upper 16 bits are nonzero; vf=0.
  - 12–15 reserved: R=a; flags keep their previous values.
- zf=(R==0) and nf=R[15] for every op except reserved. For CMP they come from a-b.
- MUL sequencing:
  - On accept: latch a and b, clear the 32-bit accumulator, load count=16, enter MUL, `busy`=1.
  - Each MUL cycle: if the multiplier LSB is 1, add the shifted multiplicand into the accumulator; shift the multiplicand left and the multiplier right; decrement count.
  - On the edge where count reaches 0: write `alu_out`/flags, pulse `en_out`, clear `busy`, return to IDLE.
- Upstream changes to `alu_a`/`alu_b`/`alu_func` during MUL have no effect.

## Timing
- Single-cycle op accepted at edge N:
  - `alu_out`/flags valid after edge N.
  - `en_out`=1 for the cycle between edges N and N+1 only.
- Back-to-back single-cycle ops accepted on consecutive edges: `en_out` stays high continuously, and each cycle carries that op's result.
- MUL accepted at edge N:
  - `busy`=1 after edges N through N+15.
  - Result and `en_out` pulse after edge N+16; `busy`=0 after edge N+16.
  - A new op is accepted no earlier than edge N+17.
- `en_in`=1 while `busy`=1: dropped. No state change; no later replay.
- When no op is accepted, `en_out`=0; `alu_out` and flags hold.
- Reset mid-MUL: the edge with `rst`=0 aborts the operation. `busy`=0 and outputs are 0 after that edge, with no `en_out` pulse.
- Reset has priority over `en_in` on the same edge.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `en_in`=1 -> all outputs 0, `busy`=0, no `en_out`.
- ADD overflow: a=0x7FFF, b=0x0001, func=0 -> `alu_out`=0x8000, nf=1, vf=1, cf=0, zf=0; `en_out` high exactly one cycle after accept.
- SUB then CMP:
  - a=0x0003, b=0x0005, func=1 -> 0xFFFE, cf=1, nf=1.
  - Next cycle a=5, b=5, func=10 -> zf=1, cf=0, `alu_out` still 0xFFFE.
- Shifts:
  - SHR 0x8001 by 1 -> 0x4000, cf=1.
  - SAR 0x8000 by 15 -> 0xFFFF, nf=1.
  - SHL 0x1234 by 0 -> 0x1234, cf=0.
- MUL with stall: 0x0100 × 0x0100, func=11 -> `busy` high 16 cycles; `en_in` pulses mid-run ignored; after edge N+16 `alu_out`=0x0000, zf=1, cf=1, one `en_out`. Also check 0x00FF × 0x0003 -> 0x02FD, cf=0.
- Reset mid-MUL: assert `rst`=0 at edge N+5 -> after that edge `busy`=0 and outputs 0; no `en_out` at N+16; a subsequent ADD 1+1 -> 0x0002.
